ahb_decode_mux_n: RTL and testbench
===================================

# ahb_decode_mux_n

Parametrised AHB-Lite address decoder and slave-response multiplexer for the SoC bus, sitting between the Cortex-M0 master port and up to 8 AHB-Lite slaves. Decodes each address phase against a base/mask table, registers the selection into the data phase, and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master. Includes a built-in default slave that answers unmapped accesses with the standard two-cycle AHB ERROR response.

## Interface
- NUM_SLAVES, 4, number of mapped slaves, legal range 1..8
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLAVE_BASE, {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_W base addresses; slot i at bits [i*ADDR_W +: ADDR_W]
- SLAVE_MASK, {4{32'hF000_0000}}, packed NUM_SLAVES*ADDR_W match masks, same packing
- HCLK  in  1  bus clock, single clock domain
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  ADDR_W  master address
- HTRANS  in  2  master transfer type
- HREADY  out  1  ready to master; also fed back to all slaves as their HREADY input
- HSEL  out  NUM_SLAVES  one-hot slave select, address phase
- HRDATA_S  in  NUM_SLAVES*DATA_W  packed slave read data
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs
- HRESP_S  in  NUM_SLAVES  slave responses (1 = ERROR)
- HRDATA  out  DATA_W  read data to master
- HRESP  out  1  response to master

## Operation
- Decode (combinational): slot i hits when (HADDR & MASK_i) == BASE_i. Lowest hitting index wins on overlap; HSEL is one-hot or all-zero. No hit -> default slave (index NUM_SLAVES), HSEL = 0.
- HSEL is driven from HADDR regardless of HTRANS.
- Data-phase select register dsel: loads decoded index (default slave = NUM_SLAVES) plus a "transfer active" bit (HTRANS[1]) on each HCLK edge where HREADY = 1; holds while HREADY = 0.
- Output mux: dsel < NUM_SLAVES -> HRDATA/HREADY/HRESP = that slave's HRDATA_S/HREADYOUT_S/HRESP_S. dsel = default -> default-slave outputs, HRDATA = 0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: HREADY=1, HRESP=0. Go DS_ERR1 when address phase captured with unmapped address and HTRANS = NONSEQ/SEQ.
  - DS_ERR1: HREADY=0, HRESP=1; unconditionally -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1; -> DS_ERR1 if another unmapped NONSEQ/SEQ is captured this edge, else DS_IDLE.
- IDLE/BUSY to unmapped address: zero-wait OKAY.

## Timing
- Zero added latency: decode is combinational in address phase; response path combinational from dsel and slave outputs.
- Reset values (async, immediate): dsel = default, active = 0, FSM = DS_IDLE; thus HREADY = 1, HRESP = 0, HRDATA = 0; HSEL follows HADDR.
- Slave wait states: HREADYOUT_S low holds dsel; next address phase not captured until HREADY = 1.
- Master changing HTRANS to IDLE during DS_ERR1 (legal AHB cancel): not captured (HREADY = 0); captured in DS_ERR2 edge.
- Back-to-back transfers to different slaves: dsel switches on the single HREADY-high edge, no bubble.
- Reset mid-wait or mid-ERROR: FSM returns to DS_IDLE, HREADY forced 1 asynchronously; slave state is the slave's concern.

## Configuration
- AHB_DECODE_MUX_ERR_RESP_EN defined: default slave FSM as above (two-cycle ERROR on unmapped NONSEQ/SEQ).
- Undefined: FSM not built; default slave always HREADY=1, HRESP=0, HRDATA=0 (unmapped accesses silently read zero, writes dropped). Decode, dsel and mux unchanged.

## Test plan
- Reset: assert HRESET with HADDR = 32'h2000_0010 -> HREADY=1, HRESP=0, HRDATA=0, HSEL=4'b0100 throughout reset.
- Mapped read: NONSEQ to 32'h1000_0004, slave1 HRDATA_S=32'hCAFE_0001 with 2 wait cycles -> HREADY low 2 cycles, then HRDATA=32'hCAFE_0001, HRESP=0.
- Back-to-back: NONSEQ to 32'h0000_0000 then 32'h4000_0000, both zero-wait -> consecutive data phases return slave0 then slave3 data, no idle cycle.
- Unmapped (macro on): NONSEQ to 32'h8000_0000 -> cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1, then OKAY; IDLE to same address -> zero-wait OKAY.
- Overlap: SLAVE_MASK slot0 = 32'h0000_0000 (matches all) -> any address selects slave0 only, HSEL=4'b0001.
- Macro off: NONSEQ to 32'h8000_0000 -> HREADY=1, HRESP=0, HRDATA=0 in data phase.

Source files
------------

// File: rtl/ahb_decode_mux_n_if.sv
// AHB-Lite bus bundle between the master port, the decoder/mux and up to 8 slaves.
// Signal names keep the AHB spelling used by the surrounding SoC.
interface ahb_decode_mux_n_if #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic                         HREADY;
    logic [NUM_SLAVES-1:0]        HSEL;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S;
    logic [NUM_SLAVES-1:0]        HREADYOUT_S;
    logic [NUM_SLAVES-1:0]        HRESP_S;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HRESP;

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HREADY, HSEL, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HREADY, HSEL, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_decode_mux_n.sv
// AHB-Lite address decoder + slave response mux with built-in default slave.
// Define AHB_DECODE_MUX_ERR_RESP_EN for the two-cycle ERROR on unmapped NONSEQ/SEQ.
module ahb_decode_mux_n #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hF000_0000}}
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_decode_mux_n_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_SLAVES + 1);
    localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(NUM_SLAVES);

    logic [SEL_W-1:0]      dec_idx;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] hsel;
    logic [SEL_W-1:0]      dsel;
    logic                  hready;
    logic                  hresp;
    logic [DATA_W-1:0]     hrdata;
    logic                  def_ready;
    logic                  def_resp;

    // Lowest matching slot wins; no match selects the default slave.
    always_comb begin
        dec_idx = DEF_IDX;
        dec_hit = 1'b0;
        hsel    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit &&
                ((bus.HADDR & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
                hsel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel <= DEF_IDX;
        end else if (hready) begin
            dsel <= dec_idx;
        end
    end

    always_comb begin
        hrdata = '0;
        hready = def_ready;
        hresp  = def_resp;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == SEL_W'(i)) begin
                hrdata = bus.HRDATA_S[i*DATA_W +: DATA_W];
                hready = bus.HREADYOUT_S[i];
                hresp  = bus.HRESP_S[i];
            end
        end
    end

`ifdef AHB_DECODE_MUX_ERR_RESP_EN
    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    ds_state_t ds_state;
    ds_state_t ds_state_nxt;
    logic      active;
    logic      capture_err;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            active   <= 1'b0;
            ds_state <= DS_IDLE;
        end else begin
            if (hready) begin
                active <= bus.HTRANS[1];
            end
            ds_state <= ds_state_nxt;
        end
    end

    assign capture_err = hready && !dec_hit && bus.HTRANS[1];

    // Outputs kept apart from next-state so hready -> capture_err is not a loop.
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                def_ready = !active;
                def_resp  = 1'b1;
            end
            DS_ERR2: def_resp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ds_state_nxt = ds_state;
        case (ds_state)
            DS_IDLE: if (capture_err) ds_state_nxt = DS_ERR1;
            DS_ERR1: ds_state_nxt = DS_ERR2;
            DS_ERR2: ds_state_nxt = capture_err ? DS_ERR1 : DS_IDLE;
            default: ds_state_nxt = DS_IDLE;
        endcase
    end
`else
    assign def_ready = 1'b1;
    assign def_resp  = 1'b0;
`endif

    assign bus.HSEL   = hsel;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;
endmodule

// File: tb/tb_ahb_decode_mux_n.sv
// Directed bench for ahb_decode_mux_n; follows AHB_DECODE_MUX_ERR_RESP_EN if defined.
module tb_ahb_decode_mux_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ahb_decode_mux_n_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) u_if ();
    ahb_decode_mux_n_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) o_if ();

    ahb_decode_mux_n #(
        .NUM_SLAVES(4),
        .ADDR_W(32),
        .DATA_W(32),
        .SLAVE_BASE({32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK({4{32'hF000_0000}})
    ) u_dut (
        .HCLK(clk),
        .HRESET(rst),
        .bus(u_if)
    );

    // Slot 0 mask of zero matches every address.
    ahb_decode_mux_n #(
        .NUM_SLAVES(4),
        .ADDR_W(32),
        .DATA_W(32),
        .SLAVE_BASE({32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h0000_0000})
    ) o_dut (
        .HCLK(clk),
        .HRESET(rst),
        .bus(o_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        u_if.HADDR       = 32'h2000_0010;
        u_if.HTRANS      = 2'b10;
        u_if.HRDATA_S    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        u_if.HREADYOUT_S = 4'b1011;
        u_if.HRESP_S     = 4'b0100;
        o_if.HADDR       = 32'h0;
        o_if.HTRANS      = 2'b00;
        o_if.HRDATA_S    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        o_if.HREADYOUT_S = 4'b1111;
        o_if.HRESP_S     = 4'b0000;

        // Reset: default slave selected, HSEL still follows HADDR.
        cyc(); #2;
        chk("rst_hready", 32'(u_if.HREADY), 32'h1);
        chk("rst_hresp",  32'(u_if.HRESP),  32'h0);
        chk("rst_hrdata", u_if.HRDATA,      32'h0);
        chk("rst_hsel",   32'(u_if.HSEL),   32'h4);
        cyc(); #2;
        chk("rst_hready2", 32'(u_if.HREADY), 32'h1);

        cyc();
        rst = 1'b0;
        u_if.HADDR = 32'h0; u_if.HTRANS = 2'b00;
        u_if.HREADYOUT_S = 4'b1111; u_if.HRESP_S = 4'b0000;

        // Mapped read to slave1 with two wait states; next address held meanwhile.
        cyc();
        u_if.HADDR = 32'h1000_0004; u_if.HTRANS = 2'b10; u_if.HREADYOUT_S[1] = 1'b0;
        #2;
        chk("rd_hsel",   32'(u_if.HSEL),   32'h2);
        chk("rd_addr_rdy", 32'(u_if.HREADY), 32'h1);
        cyc();
        u_if.HADDR = 32'h4000_0000; u_if.HTRANS = 2'b10;
        #2;
        chk("rd_wait1", 32'(u_if.HREADY), 32'h0);
        cyc(); #2;
        chk("rd_wait2", 32'(u_if.HREADY), 32'h0);
        cyc();
        u_if.HREADYOUT_S[1] = 1'b1;
        #2;
        chk("rd_done_rdy",  32'(u_if.HREADY), 32'h1);
        chk("rd_done_data", u_if.HRDATA,      32'hCAFE_0001);
        chk("rd_done_resp", 32'(u_if.HRESP),  32'h0);

        // Back-to-back: slave3, slave0, slave3 data phases with no bubble.
        cyc();
        u_if.HADDR = 32'h0000_0000; u_if.HTRANS = 2'b10;
        #2;
        chk("b2b_s3_data", u_if.HRDATA,      32'hCAFE_0003);
        chk("b2b_s3_rdy",  32'(u_if.HREADY), 32'h1);
        cyc();
        u_if.HADDR = 32'h4000_0000; u_if.HTRANS = 2'b10;
        #2;
        chk("b2b_s0_data", u_if.HRDATA, 32'hCAFE_0000);
        cyc();
        u_if.HADDR = 32'h8000_0000; u_if.HTRANS = 2'b10;
        #2;
        chk("b2b_s3b_data", u_if.HRDATA,    32'hCAFE_0003);
        chk("unmap_hsel",   32'(u_if.HSEL), 32'h0);

        // Unmapped NONSEQ, then IDLE to the same address.
        cyc();
        u_if.HTRANS = 2'b00;
        #2;
`ifdef AHB_DECODE_MUX_ERR_RESP_EN
        chk("err1_rdy",  32'(u_if.HREADY), 32'h0);
        chk("err1_resp", 32'(u_if.HRESP),  32'h1);
`else
        chk("noerr_rdy",  32'(u_if.HREADY), 32'h1);
        chk("noerr_resp", 32'(u_if.HRESP),  32'h0);
`endif
        chk("unmap_data", u_if.HRDATA, 32'h0);
        cyc(); #2;
`ifdef AHB_DECODE_MUX_ERR_RESP_EN
        chk("err2_rdy",  32'(u_if.HREADY), 32'h1);
        chk("err2_resp", 32'(u_if.HRESP),  32'h1);
`else
        chk("noerr2_rdy",  32'(u_if.HREADY), 32'h1);
        chk("noerr2_resp", 32'(u_if.HRESP),  32'h0);
`endif
        cyc();
        u_if.HTRANS = 2'b10;
        #2;
        chk("idle_unmap_rdy",  32'(u_if.HREADY), 32'h1);
        chk("idle_unmap_resp", 32'(u_if.HRESP),  32'h0);

        // Consecutive unmapped NONSEQs: ERR2 edge captures the next one.
        cyc(); #2;
`ifdef AHB_DECODE_MUX_ERR_RESP_EN
        chk("b2b_err1_rdy", 32'(u_if.HREADY), 32'h0);
`else
        chk("b2b_ok1_rdy", 32'(u_if.HREADY), 32'h1);
`endif
        cyc(); #2;
`ifdef AHB_DECODE_MUX_ERR_RESP_EN
        chk("b2b_err2_resp", 32'(u_if.HRESP),  32'h1);
        chk("b2b_err2_rdy",  32'(u_if.HREADY), 32'h1);
`else
        chk("b2b_ok2_resp", 32'(u_if.HRESP), 32'h0);
`endif
        cyc();
        u_if.HADDR = 32'h0; u_if.HTRANS = 2'b00;
        #2;
`ifdef AHB_DECODE_MUX_ERR_RESP_EN
        chk("b2b_err1b_rdy",  32'(u_if.HREADY), 32'h0);
        chk("b2b_err1b_resp", 32'(u_if.HRESP),  32'h1);
`else
        chk("b2b_ok3_rdy", 32'(u_if.HREADY), 32'h1);
`endif
        // Asynchronous reset in the middle of the error response.
        rst = 1'b1;
        #1;
        chk("midrst_rdy",  32'(u_if.HREADY), 32'h1);
        chk("midrst_resp", 32'(u_if.HRESP),  32'h0);
        cyc();
        rst = 1'b0;

        // Overlapping decode: everything lands on slave0.
        o_if.HADDR = 32'h1000_0004; #1;
        chk("ovl_hsel_1", 32'(o_if.HSEL), 32'h1);
        o_if.HADDR = 32'h4000_0000; #1;
        chk("ovl_hsel_4", 32'(o_if.HSEL), 32'h1);
        o_if.HADDR = 32'h8000_0000; #1;
        chk("ovl_hsel_8", 32'(o_if.HSEL), 32'h1);
        cyc();
        o_if.HADDR = 32'h2000_0000; o_if.HTRANS = 2'b10;
        cyc();
        o_if.HTRANS = 2'b00;
        #2;
        chk("ovl_data", o_if.HRDATA,      32'hCAFE_0000);
        chk("ovl_rdy",  32'(o_if.HREADY), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
